alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Hardwired control sequencer driving the Datapath control inputs for ALU
//  register/immediate instructions. Fetches a word at PC, latches it into IR,
//  decodes it and steps the Datapath through fetch, operand load, execute and writeback.
//  Sits between instruction memory and Datapath; replaces hand-driven control.
// PARAMETERS
//  IMM_W     19  width of IR immediate field C, sign-extended to 32 bits
//  FETCH_TO  15  max cycles waiting on iMemRdy in T0 before oIllegal is raised
// PORTS
//  iClk        in   1   clock, all state on rising edge
//  iRst        in   1   synchronous, active-high reset
//  iRun        in   1   level; 1 = keep issuing instructions
//  iMemData    in   32  instruction word from memory
//  iMemRdy     in   1   iMemData valid this cycle
//  oIR         out  32  instruction register
//  oPC_en, oPC_jmp, oMUX_MAP  out 1  PC increment / PC-to-address select
//  oRF_AddrA, oRF_AddrB, oRF_AddrC  out 4  register file addresses
//  oRF_Write, oRWB_en, oRA_en, oRB_en, oRZH_en, oRZL_en  out 1  register enables
//  oALU_Ctrl   out  4   ALU operation (CTRL_ALU_* encodings)
//  oMUX_BIS, oMUX_RZHS, oMUX_ASS, oMUX_WBM, oMUX_WBP  out 1  Datapath mux selects
//  oImm32      out  32  sign-extended C field
//  oBusy       out  1   1 in any state other than IDLE
//  oDone       out  1   one-cycle pulse in T5 (writeback cycle)
//  oIllegal    out  1   sticky; set on bad opcode or fetch timeout, cleared by iRst
// BEHAVIOUR
//  - Reset: state=IDLE, oIR=0, every output 0, timeout counter 0, oIllegal=0.
//  - IR fields: op=IR[31:27], Ra=IR[26:23] (dest), Rb=IR[22:19], Rc=IR[18:15], C=IR[18:0].
//  - Outputs are Moore: function of registered state and oIR only.
//  - IDLE: all enables 0; iRun=1 -> T0.
//  - T0 fetch: oMUX_MAP=1; wait for iMemRdy. iMemRdy=1 -> IR<=iMemData, -> T1.
//    Counter increments each wait cycle; reaching FETCH_TO -> oIllegal=1, -> IDLE.
//  - T1: oPC_en=1, oPC_jmp=1 for exactly one cycle (PC+1); decode op. Unsupported
//    op -> oIllegal=1, -> IDLE, no register enable asserted. Else -> T2.
//  - T2: oRF_AddrA=Rb, oRF_AddrB=Rc, oRA_en=1, oRB_en=1; oMUX_BIS=1 for
//    ADDI/ANDI/ORI (B operand = oImm32), 0 otherwise. -> T3.
//  - T3: oALU_Ctrl per op, oRZH_en=oRZL_en=1, oMUX_RZHS=0, oMUX_ASS=0. -> T4.
//  - T4: oRWB_en=1, oMUX_WBM=0, oMUX_WBP=0 (ZLow into RWB). -> T5.
//  - T5: oRF_AddrC=Ra, oRF_Write=1, oDone=1. -> T0 if iRun=1, else IDLE.
//  - Supported ops: ADD SUB AND OR SHR SHL ROR ROL NEG NOT ADDI ANDI ORI; NEG/NOT ignore Rc.
//  - Mux selects and oALU_Ctrl hold their T2/T3 values through T5;
//    all enables are single-cycle.
//  - iRun deasserted mid-instruction: current instruction completes through T5.
//  - iRst mid-instruction: immediate return to IDLE; no oRF_Write in reset cycle
//    or after; partial instruction discarded.
//  - Write to R0 (Ra=0) issued normally; R0 handling is Datapath's concern.
//  - Instruction latency with iMemRdy in first T0 cycle: 6 cycles T0..T5.
// TESTING
//  - OR R4,R3,R7 with R3=0x22, R7=0x24, iMemRdy immediate -> oRF_Write in cycle 6,
//    oRF_AddrC=4, R4=0x26, oDone one pulse, oPC_en exactly one pulse.
//  - ADDI R2,R1,-5 (C=0x7FFFB), R1=10 -> oImm32=0xFFFFFFFB, oMUX_BIS=1 in T2, R2=5.
//  - iMemRdy held low 3 cycles then high -> T0 lasts 4 cycles, result unchanged;
//    held low FETCH_TO cycles -> oIllegal=1, IDLE, no oRF_Write.
//  - Opcode outside supported set -> oIllegal=1 after T1, no RA/RB/RZ/RWB/RF enables.
//  - iRst asserted in T4 -> next cycle IDLE, all outputs 0, no oRF_Write.
//  - iRun=1 for two back-to-back ANDs, iRun dropped during second -> both write back,
//    then IDLE; oBusy falls the cycle after second oDone.

Source files
------------

// File: rtl/alu_sequencer.sv
// Hardwired control sequencer for ALU register/immediate instructions.
// Fetches into IR, decodes, and steps the Datapath through T0..T5 with registered Moore outputs.
module alu_sequencer #(
  parameter int unsigned IMM_W    = 19,
  parameter int unsigned FETCH_TO = 15
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iRun,
  input  logic [31:0] iMemData,
  input  logic        iMemRdy,
  output logic [31:0] oIR,
  output logic        oPC_en,
  output logic        oPC_jmp,
  output logic        oMUX_MAP,
  output logic [3:0]  oRF_AddrA,
  output logic [3:0]  oRF_AddrB,
  output logic [3:0]  oRF_AddrC,
  output logic        oRF_Write,
  output logic        oRWB_en,
  output logic        oRA_en,
  output logic        oRB_en,
  output logic        oRZH_en,
  output logic        oRZL_en,
  output logic [3:0]  oALU_Ctrl,
  output logic        oMUX_BIS,
  output logic        oMUX_RZHS,
  output logic        oMUX_ASS,
  output logic        oMUX_WBM,
  output logic        oMUX_WBP,
  output logic [31:0] oImm32,
  output logic        oBusy,
  output logic        oDone,
  output logic        oIllegal
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(FETCH_TO + 1);

  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_SUB  = 5'd4;
  localparam logic [4:0] OP_AND  = 5'd5;
  localparam logic [4:0] OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7;
  localparam logic [4:0] OP_SHL  = 5'd8;
  localparam logic [4:0] OP_ROR  = 5'd9;
  localparam logic [4:0] OP_ROL  = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ANDI = 5'd12;
  localparam logic [4:0] OP_ORI  = 5'd13;
  localparam logic [4:0] OP_NEG  = 5'd16;
  localparam logic [4:0] OP_NOT  = 5'd17;

  localparam logic [3:0] CTRL_ALU_ADD = 4'd0;
  localparam logic [3:0] CTRL_ALU_SUB = 4'd1;
  localparam logic [3:0] CTRL_ALU_AND = 4'd2;
  localparam logic [3:0] CTRL_ALU_OR  = 4'd3;
  localparam logic [3:0] CTRL_ALU_SHR = 4'd4;
  localparam logic [3:0] CTRL_ALU_SHL = 4'd5;
  localparam logic [3:0] CTRL_ALU_ROR = 4'd6;
  localparam logic [3:0] CTRL_ALU_ROL = 4'd7;
  localparam logic [3:0] CTRL_ALU_NEG = 4'd8;
  localparam logic [3:0] CTRL_ALU_NOT = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5
  } state_t;

  typedef struct packed {
    logic       pc_en;
    logic       pc_jmp;
    logic       mux_map;
    logic [3:0] addr_a;
    logic [3:0] addr_b;
    logic [3:0] addr_c;
    logic       rf_write;
    logic       rwb_en;
    logic       ra_en;
    logic       rb_en;
    logic       rzh_en;
    logic       rzl_en;
    logic [3:0] alu_ctrl;
    logic       mux_bis;
    logic       mux_rzhs;
    logic       mux_ass;
    logic       mux_wbm;
    logic       mux_wbp;
    logic       busy;
    logic       done;
  } ctrl_t;

  function automatic logic op_supported(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
      OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT: op_supported = 1'b1;
      default:                                  op_supported = 1'b0;
    endcase
  endfunction

  function automatic logic op_is_imm(input logic [4:0] op);
    op_is_imm = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI);
  endfunction

  function automatic logic [3:0] op_alu(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI: op_alu = CTRL_ALU_ADD;
      OP_SUB:          op_alu = CTRL_ALU_SUB;
      OP_AND, OP_ANDI: op_alu = CTRL_ALU_AND;
      OP_OR, OP_ORI:   op_alu = CTRL_ALU_OR;
      OP_SHR:          op_alu = CTRL_ALU_SHR;
      OP_SHL:          op_alu = CTRL_ALU_SHL;
      OP_ROR:          op_alu = CTRL_ALU_ROR;
      OP_ROL:          op_alu = CTRL_ALU_ROL;
      OP_NEG:          op_alu = CTRL_ALU_NEG;
      OP_NOT:          op_alu = CTRL_ALU_NOT;
      default:         op_alu = CTRL_ALU_ADD;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]   imm_q, imm_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                illegal_q, illegal_d;
  ctrl_t               ctrl_q, ctrl_d;

  logic [4:0] op_d;
  logic [3:0] ra_d, rb_d, rc_d;

  assign op_d  = ir_d[31:27];
  assign ra_d  = ir_d[26:23];
  assign rb_d  = ir_d[22:19];
  assign rc_d  = ir_d[18:15];
  assign imm_d = {{(DATA_W - IMM_W){ir_d[IMM_W-1]}}, ir_d[IMM_W-1:0]};

  // Sequencing, fetch timeout and sticky illegal flag
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (iRun) begin
          state_d = S_T0;
          cnt_d   = '0;
        end
      end
      S_T0: begin
        if (iMemRdy) begin
          ir_d    = iMemData;
          state_d = S_T1;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(FETCH_TO - 1)) begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_T1: begin
        if (op_supported(ir_q[31:27])) begin
          state_d = S_T2;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_T2: state_d = S_T3;
      S_T3: state_d = S_T4;
      S_T4: state_d = S_T5;
      S_T5: begin
        if (iRun) begin
          state_d = S_T0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs decoded from the upcoming state/IR so they register in step with it
  always_comb begin
    ctrl_d      = '0;
    ctrl_d.busy = (state_d != S_IDLE);
    case (state_d)
      S_T0: ctrl_d.mux_map = 1'b1;
      S_T1: begin
        ctrl_d.pc_en  = 1'b1;
        ctrl_d.pc_jmp = 1'b1;
      end
      S_T2: begin
        ctrl_d.addr_a  = rb_d;
        ctrl_d.addr_b  = rc_d;
        ctrl_d.ra_en   = 1'b1;
        ctrl_d.rb_en   = 1'b1;
        ctrl_d.mux_bis = op_is_imm(op_d);
      end
      S_T3: begin
        ctrl_d.mux_bis  = op_is_imm(op_d);
        ctrl_d.alu_ctrl = op_alu(op_d);
        ctrl_d.rzh_en   = 1'b1;
        ctrl_d.rzl_en   = 1'b1;
      end
      S_T4: begin
        ctrl_d.mux_bis  = op_is_imm(op_d);
        ctrl_d.alu_ctrl = op_alu(op_d);
        ctrl_d.rwb_en   = 1'b1;
      end
      S_T5: begin
        ctrl_d.mux_bis  = op_is_imm(op_d);
        ctrl_d.alu_ctrl = op_alu(op_d);
        ctrl_d.addr_c   = ra_d;
        ctrl_d.rf_write = 1'b1;
        ctrl_d.done     = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      imm_q     <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      imm_q     <= imm_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign oIR       = ir_q;
  assign oImm32    = imm_q;
  assign oIllegal  = illegal_q;
  assign oPC_en    = ctrl_q.pc_en;
  assign oPC_jmp   = ctrl_q.pc_jmp;
  assign oMUX_MAP  = ctrl_q.mux_map;
  assign oRF_AddrA = ctrl_q.addr_a;
  assign oRF_AddrB = ctrl_q.addr_b;
  assign oRF_AddrC = ctrl_q.addr_c;
  assign oRF_Write = ctrl_q.rf_write;
  assign oRWB_en   = ctrl_q.rwb_en;
  assign oRA_en    = ctrl_q.ra_en;
  assign oRB_en    = ctrl_q.rb_en;
  assign oRZH_en   = ctrl_q.rzh_en;
  assign oRZL_en   = ctrl_q.rzl_en;
  assign oALU_Ctrl = ctrl_q.alu_ctrl;
  assign oMUX_BIS  = ctrl_q.mux_bis;
  assign oMUX_RZHS = ctrl_q.mux_rzhs;
  assign oMUX_ASS  = ctrl_q.mux_ass;
  assign oMUX_WBM  = ctrl_q.mux_wbm;
  assign oMUX_WBP  = ctrl_q.mux_wbp;
  assign oBusy     = ctrl_q.busy;
  assign oDone     = ctrl_q.done;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a datapath model driven by the DUT's controls
// is compared against an opcode-level reference executed at issue time.
module tb_alu_sequencer;

  localparam int unsigned FETCH_TO = 15;

  localparam logic [4:0] OP_ADD = 5'd3,  OP_SUB = 5'd4,  OP_AND = 5'd5,  OP_OR = 5'd6;
  localparam logic [4:0] OP_SHR = 5'd7,  OP_SHL = 5'd8,  OP_ROR = 5'd9,  OP_ROL = 5'd10;
  localparam logic [4:0] OP_ADDI = 5'd11, OP_ANDI = 5'd12, OP_ORI = 5'd13;
  localparam logic [4:0] OP_NEG = 5'd16, OP_NOT = 5'd17;

  logic        iClk = 1'b0;
  logic        iRst, iRun, iMemRdy;
  logic [31:0] iMemData;
  logic [31:0] oIR, oImm32;
  logic        oPC_en, oPC_jmp, oMUX_MAP, oRF_Write, oRWB_en, oRA_en, oRB_en, oRZH_en, oRZL_en;
  logic [3:0]  oRF_AddrA, oRF_AddrB, oRF_AddrC, oALU_Ctrl;
  logic        oMUX_BIS, oMUX_RZHS, oMUX_ASS, oMUX_WBM, oMUX_WBP, oBusy, oDone, oIllegal;

  alu_sequencer #(.IMM_W(19), .FETCH_TO(FETCH_TO)) dut (
    .iClk(iClk), .iRst(iRst), .iRun(iRun), .iMemData(iMemData), .iMemRdy(iMemRdy),
    .oIR(oIR), .oPC_en(oPC_en), .oPC_jmp(oPC_jmp), .oMUX_MAP(oMUX_MAP),
    .oRF_AddrA(oRF_AddrA), .oRF_AddrB(oRF_AddrB), .oRF_AddrC(oRF_AddrC),
    .oRF_Write(oRF_Write), .oRWB_en(oRWB_en), .oRA_en(oRA_en), .oRB_en(oRB_en),
    .oRZH_en(oRZH_en), .oRZL_en(oRZL_en), .oALU_Ctrl(oALU_Ctrl), .oMUX_BIS(oMUX_BIS),
    .oMUX_RZHS(oMUX_RZHS), .oMUX_ASS(oMUX_ASS), .oMUX_WBM(oMUX_WBM), .oMUX_WBP(oMUX_WBP),
    .oImm32(oImm32), .oBusy(oBusy), .oDone(oDone), .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  logic [96:0] all_out;
  assign all_out = {oIR, oPC_en, oPC_jmp, oMUX_MAP, oRF_AddrA, oRF_AddrB, oRF_AddrC,
                    oRF_Write, oRWB_en, oRA_en, oRB_en, oRZH_en, oRZL_en, oALU_Ctrl,
                    oMUX_BIS, oMUX_RZHS, oMUX_ASS, oMUX_WBM, oMUX_WBP, oImm32,
                    oBusy, oDone, oIllegal};

  typedef struct {
    logic [3:0]  rd;
    logic [31:0] val;
    int          lat;
    logic        bis;
    logic [31:0] imm;
    logic [31:0] ir;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] rf_ref[16];
  logic [31:0] rf_dp[16];
  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          exp_done = 0;
  bit          expect_no_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  function automatic bit is_imm_op(input logic [4:0] op);
    return op == OP_ADDI || op == OP_ANDI || op == OP_ORI;
  endfunction

  // Architectural meaning of each opcode
  function automatic logic [31:0] ref_exec(input logic [4:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] r;
    int s;
    s = int'(b[4:0]);
    r = a;
    case (op)
      OP_ADD:  r = a + b;
      OP_SUB:  r = a - b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_SHR:  r = a >> s;
      OP_SHL:  r = a << s;
      OP_ROR:  for (int i = 0; i < s; i++) r = {r[0], r[31:1]};
      OP_ROL:  for (int i = 0; i < s; i++) r = {r[30:0], r[31]};
      OP_ADDI: r = a + imm;
      OP_ANDI: r = a & imm;
      OP_ORI:  r = a | imm;
      OP_NEG:  r = 32'd0 - a;
      OP_NOT:  r = ~a;
      default: r = 32'hxxxxxxxx;
    endcase
    return r;
  endfunction

  // Datapath ALU keyed by control code
  function automatic logic [31:0] dp_alu(input logic [3:0] ctrl, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] t;
    case (ctrl)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a >> b[4:0];
      4'd5: return a << b[4:0];
      4'd6: begin t = {a, a} >> b[4:0]; return t[31:0];  end
      4'd7: begin t = {a, a} << b[4:0]; return t[63:32]; end
      4'd8: return -a;
      4'd9: return ~a;
      default: return 32'hDEADBEEF;
    endcase
  endfunction

  // Present a word when the DUT fetches; push the reference result first
  task automatic issue(input logic [31:0] word, input int waits, input bit push);
    exp_t e;
    int guard;
    logic [31:0] imm;
    imm = {{13{word[18]}}, word[18:0]};
    if (push) begin
      e.rd  = word[26:23];
      e.val = ref_exec(word[31:27], rf_ref[word[22:19]], rf_ref[word[18:15]], imm);
      e.lat = waits + 6;
      e.bis = is_imm_op(word[31:27]);
      e.imm = imm;
      e.ir  = word;
      rf_ref[e.rd] = e.val;
      sb_q.push_back(e);
      exp_done++;
    end
    guard = 0;
    while (oMUX_MAP !== 1'b1 && guard < 50) begin
      @(posedge iClk); #1;
      guard++;
    end
    if (guard >= 50) begin
      fail_now("fetch_wait");
      return;
    end
    repeat (waits) begin
      @(posedge iClk); #1;
    end
    iMemData = word;
    iMemRdy  = 1'b1;
    @(posedge iClk); #1;
    iMemRdy  = 1'b0;
    iMemData = $urandom;
  endtask

  task automatic wait_done(input int target);
    int guard;
    guard = 0;
    while (done_cnt < target && guard < 100) begin
      @(posedge iClk); #1;
      guard++;
    end
    if (done_cnt < target) fail_now("wait_done");
  endtask

  // Monitor: datapath model plus scoreboard compare on every write-back
  int          lat = 0;
  int          pc_cnt = 0;
  bit          in_instr = 1'b0;
  logic        bis_t2 = 1'b0;
  logic [31:0] dp_a = '0, dp_b = '0, dp_z = '0;
  exp_t        mon_e;

  always @(negedge iClk) begin
    if (oRA_en) begin
      dp_a   = rf_dp[oRF_AddrA];
      bis_t2 = oMUX_BIS;
    end
    if (oRB_en) dp_b = rf_dp[oRF_AddrB];
    if (oRZL_en) dp_z = dp_alu(oALU_Ctrl, dp_a, oMUX_BIS ? oImm32 : dp_b);
    if (expect_no_en && (oRA_en || oRB_en || oRZH_en || oRZL_en || oRWB_en || oRF_Write))
      check("no_enables", {oRA_en, oRB_en, oRZH_en, oRZL_en, oRWB_en, oRF_Write}, 0);
    if (oMUX_MAP && !in_instr) begin
      in_instr = 1'b1;
      lat      = 0;
      pc_cnt   = 0;
    end
    if (in_instr) lat++;
    if (oPC_en) pc_cnt++;
    if (oRF_Write) begin
      if (sb_q.size() == 0) begin
        fail_now("spurious_write");
      end else begin
        mon_e = sb_q.pop_front();
        check("wb_addr",    oRF_AddrC, mon_e.rd);
        check("wb_value",   dp_z,      mon_e.val);
        check("latency",    lat,       mon_e.lat);
        check("pc_pulses",  pc_cnt,    1);
        check("bis_t2",     bis_t2,    mon_e.bis);
        check("bis_hold",   oMUX_BIS,  mon_e.bis);
        check("imm32",      oImm32,    mon_e.imm);
        check("ir",         oIR,       mon_e.ir);
        check("done_pulse", oDone,     1'b1);
        done_cnt++;
      end
      rf_dp[oRF_AddrC] = dp_z;
      in_instr = 1'b0;
    end else if (oDone) begin
      fail_now("done_without_write");
    end
    if (!oBusy) in_instr = 1'b0;
  end

  initial begin
    logic [31:0] w;
    logic [4:0]  legal[13];
    int          t0;
    int          guard;
    legal = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
              OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT};
    for (int i = 0; i < 16; i++) begin
      rf_ref[i] = $urandom;
      rf_dp[i]  = rf_ref[i];
    end
    iRst = 1'b1; iRun = 1'b0; iMemRdy = 1'b0; iMemData = '0;
    repeat (2) @(posedge iClk);
    #1;
    check("rst_outputs", all_out, 0);
    check("rst_illegal", oIllegal, 1'b0);
    iRst = 1'b0;
    @(posedge iClk); #1;
    check("idle_hold", {oBusy, oMUX_MAP}, 0);

    // OR R4,R3,R7
    rf_ref[3] = 32'h22; rf_dp[3] = 32'h22;
    rf_ref[7] = 32'h24; rf_dp[7] = 32'h24;
    iRun = 1'b1;
    issue({OP_OR, 4'd4, 4'd3, 4'd7, 15'd0}, 0, 1'b1);
    iRun = 1'b0;
    wait_done(exp_done);
    check("or_r4", rf_dp[4], 32'h26);
    check("or_idle", oBusy, 1'b0);

    // ADDI R2,R1,-5
    rf_ref[1] = 32'd10; rf_dp[1] = 32'd10;
    iRun = 1'b1;
    issue({OP_ADDI, 4'd2, 4'd1, 19'h7FFFB}, 0, 1'b1);
    iRun = 1'b0;
    wait_done(exp_done);
    check("addi_r2", rf_dp[2], 32'd5);
    check("addi_imm", oImm32, 32'hFFFFFFFB);

    // Three wait cycles in T0
    iRun = 1'b1;
    issue({OP_OR, 4'd4, 4'd3, 4'd7, 15'd0}, 3, 1'b1);
    iRun = 1'b0;
    wait_done(exp_done);
    check("wait3_r4", rf_dp[4], 32'h26);

    // Back-to-back ANDs, run dropped during the second
    iRun = 1'b1;
    issue({OP_AND, 4'd5, 4'd3, 4'd7, 15'd0}, 0, 1'b1);
    issue({OP_AND, 4'd6, 4'd5, 4'd1, 15'd0}, 0, 1'b1);
    iRun = 1'b0;
    wait_done(exp_done);
    check("b2b_busy_fall", oBusy, 1'b0);
    repeat (3) @(posedge iClk);
    #1;
    check("b2b_stays_idle", {oBusy, oMUX_MAP}, 0);

    // Random back-to-back stream
    iRun = 1'b1;
    for (int n = 0; n < 40; n++) begin
      w = {legal[$urandom_range(0, 12)], 4'($urandom), 4'($urandom), 19'($urandom)};
      issue(w, $urandom_range(0, 4), 1'b1);
    end
    iRun = 1'b0;
    wait_done(exp_done);

    // Fetch timeout
    iRun = 1'b1;
    @(posedge iClk); #1;
    iRun = 1'b0;
    t0 = 0;
    while (oMUX_MAP === 1'b1 && t0 < 40) begin
      t0++;
      @(posedge iClk); #1;
    end
    check("timeout_cycles", t0, FETCH_TO);
    check("timeout_idle", oBusy, 1'b0);
    check("timeout_illegal", oIllegal, 1'b1);
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;
    check("illegal_cleared", oIllegal, 1'b0);

    // Unsupported opcode
    expect_no_en = 1'b1;
    iRun = 1'b1;
    issue({5'd20, 27'($urandom)}, 0, 1'b0);
    iRun = 1'b0;
    check("badop_pc_en", oPC_en, 1'b1);
    @(posedge iClk); #1;
    check("badop_idle", oBusy, 1'b0);
    check("badop_illegal", oIllegal, 1'b1);
    repeat (3) @(posedge iClk);
    #1;
    expect_no_en = 1'b0;
    iRst = 1'b1;
    @(posedge iClk); #1;
    iRst = 1'b0;

    // Reset during T4 discards the instruction
    iRun = 1'b1;
    issue({OP_ADD, 4'd9, 4'd1, 4'd2, 15'd0}, 0, 1'b0);
    guard = 0;
    while (oRWB_en !== 1'b1 && guard < 10) begin
      @(posedge iClk); #1;
      guard++;
    end
    check("t4_reached", oRWB_en, 1'b1);
    iRst = 1'b1;
    iRun = 1'b0;
    @(posedge iClk); #1;
    check("t4_rst_outputs", all_out, 0);
    iRst = 1'b0;
    repeat (4) @(posedge iClk);
    #1;
    check("t4_rst_idle", oBusy, 1'b0);

    // Normal operation resumes after the abort
    iRun = 1'b1;
    issue({OP_SUB, 4'd9, 4'd1, 4'd2, 15'd0}, 1, 1'b1);
    iRun = 1'b0;
    wait_done(exp_done);
    check("done_count", done_cnt, exp_done);
    check("sb_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
